// File: rtl/dispatch_sched_pkg.sv
// Shared types and constants for the dispatch scheduler: ROB pointer layout,
// FSM state encoding and the ROB idle-state code.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE 2'd0
`endif

package dispatch_sched_pkg;

  localparam int ROB_SIZE     = 64;
  localparam int ROB_SIZE_LOG = 6;

  typedef struct packed {
    logic                    flag;
    logic [ROB_SIZE_LOG-1:0] idx;
  } rob_ptr_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RECOVER  = 2'd1,
    WAIT_ROB = 2'd2
  } sched_state_e;

endpackage

// File: rtl/dispatch_sched_if.sv
// Rename-to-dispatch and dispatch-to-IQ handshake bundle; master is the
// rename/IQ environment, slave is the dispatch scheduler.
interface dispatch_sched_if
  import dispatch_sched_pkg::*;
#(
  parameter int ROB_SIZE_LOG = dispatch_sched_pkg::ROB_SIZE_LOG
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_is_load;
  logic                    in_is_store;
  logic                    alu_iq_valid;
  logic                    alu_iq_ready;
  logic                    lsu_iq_valid;
  logic                    lsu_iq_ready;
  logic                    enq_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] enq_robidx;

  modport master (
    output in_valid, in_is_load, in_is_store, alu_iq_ready, lsu_iq_ready,
    input  in_ready, alu_iq_valid, lsu_iq_valid, enq_robidx_flag, enq_robidx
  );

  modport slave (
    input  in_valid, in_is_load, in_is_store, alu_iq_ready, lsu_iq_ready,
    output in_ready, alu_iq_valid, lsu_iq_valid, enq_robidx_flag, enq_robidx
  );

endinterface

// File: rtl/dispatch_sched_rob_ptr_unit.sv
// ROB enqueue/dequeue pointers with wrap flags, flush restore of the enqueue
// pointer, and the occupancy/full/overcommit view derived from them.
module dispatch_sched_rob_ptr_unit
  import dispatch_sched_pkg::*;
#(
  parameter int ROB_SIZE     = dispatch_sched_pkg::ROB_SIZE,
  parameter int ROB_SIZE_LOG = dispatch_sched_pkg::ROB_SIZE_LOG
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fire,
  input  logic [1:0]            commit_cnt,
  input  logic                  flush_valid,
  input  logic [ROB_SIZE_LOG:0] flush_ptr,
  output logic [ROB_SIZE_LOG:0] enq_ptr,
  output logic [ROB_SIZE_LOG:0] occupancy,
  output logic                  full,
  output logic                  overcommit
);

  localparam int PW = ROB_SIZE_LOG + 1;

  logic [PW-1:0] enq_q, enq_d;
  logic [PW-1:0] deq_q, deq_d;
  logic [PW-1:0] commit_ext;
  logic [PW-1:0] occ_after;

  // The flag bit sits directly above the index, so a plain PW-bit add wraps
  // the index and toggles the flag together; the difference is the occupancy.
  assign occupancy  = enq_q - deq_q;
  assign full       = (occupancy == PW'(ROB_SIZE));
  assign commit_ext = PW'(commit_cnt);
  assign occ_after  = occupancy + PW'(fire);
  assign overcommit = (commit_ext > occ_after);
  assign enq_ptr    = enq_q;

  always_comb begin
    enq_d = enq_q;
    if (flush_valid) begin
      enq_d = flush_ptr + PW'(1);
    end else if (fire) begin
      enq_d = enq_q + PW'(1);
    end
    deq_d = deq_q + commit_ext;
    if (overcommit) begin
      deq_d = enq_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_q <= '0;
      deq_q <= '0;
    end else begin
      enq_q <= enq_d;
      deq_q <= deq_d;
    end
  end

endmodule

// File: rtl/dispatch_sched.sv
// Single-lane dispatch controller: steers renamed instructions to the ALU or
// LSU issue queue, allocates ROB indices, and sequences flush recovery.
module dispatch_sched
  import dispatch_sched_pkg::*;
#(
  parameter int ROB_SIZE     = dispatch_sched_pkg::ROB_SIZE,
  parameter int ROB_SIZE_LOG = dispatch_sched_pkg::ROB_SIZE_LOG,
  parameter int PERF_W       = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  dispatch_sched_if.slave         bus,
  output logic [ROB_SIZE_LOG:0]   rob_occupancy,
  input  logic [1:0]              commit_cnt,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
  input  logic [1:0]              rob_state,
  output logic [1:0]              sched_state,
  output logic                    err_overcommit,
  output logic [PERF_W-1:0]       stall_rob_full_cnt,
  output logic [PERF_W-1:0]       stall_iq_cnt
);

  sched_state_e          state_q, state_d;
  logic                  is_lsu;
  logic                  target_ready;
  logic                  rob_idle;
  logic                  run_open;
  logic                  go;
  logic                  fire;
  logic                  full;
  logic                  overcommit;
  logic [ROB_SIZE_LOG:0] enq_ptr;
  logic                  err_q;
  logic [PERF_W-1:0]     rob_full_q;
  logic [PERF_W-1:0]     iq_stall_q;

  // IQ valids deliberately ignore the IQ's own ready; only in_ready waits on it.
  assign is_lsu       = bus.in_is_load | bus.in_is_store;
  assign target_ready = is_lsu ? bus.lsu_iq_ready : bus.alu_iq_ready;
  assign rob_idle     = (rob_state == `ROB_STATE_IDLE);
  assign run_open     = (state_q == RUN) & ~flush_valid & ~full & rob_idle;
  assign go           = bus.in_valid & run_open;
  assign fire         = bus.in_valid & bus.in_ready;

  assign bus.alu_iq_valid    = go & ~is_lsu;
  assign bus.lsu_iq_valid    = go & is_lsu;
  assign bus.in_ready        = run_open & target_ready;
  assign bus.enq_robidx_flag = enq_ptr[ROB_SIZE_LOG];
  assign bus.enq_robidx      = enq_ptr[ROB_SIZE_LOG-1:0];

  assign sched_state        = state_q;
  assign err_overcommit     = err_q;
  assign stall_rob_full_cnt = rob_full_q;
  assign stall_iq_cnt       = iq_stall_q;

  dispatch_sched_rob_ptr_unit #(
    .ROB_SIZE     (ROB_SIZE),
    .ROB_SIZE_LOG (ROB_SIZE_LOG)
  ) u_rob_ptr_unit (
    .clock       (clock),
    .reset       (reset),
    .fire        (fire),
    .commit_cnt  (commit_cnt),
    .flush_valid (flush_valid),
    .flush_ptr   ({flush_robidx_flag, flush_robidx}),
    .enq_ptr     (enq_ptr),
    .occupancy   (rob_occupancy),
    .full        (full),
    .overcommit  (overcommit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush overrides every other transition, including one already in recovery.
  always_comb begin
    state_d = state_q;
    if (flush_valid) begin
      state_d = RECOVER;
    end else begin
      case (state_q)
        RUN:      state_d = RUN;
        RECOVER:  state_d = WAIT_ROB;
        WAIT_ROB: state_d = rob_idle ? RUN : WAIT_ROB;
        default:  state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (overcommit) begin
      err_q <= 1'b1;
    end
  end

  // Stall counters hold at all-ones rather than wrapping back to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rob_full_q <= '0;
      iq_stall_q <= '0;
    end else begin
      if (bus.in_valid & (state_q == RUN) & ~flush_valid & full & (rob_full_q != '1)) begin
        rob_full_q <= rob_full_q + PERF_W'(1);
      end
      if (go & ~target_ready & (iq_stall_q != '1)) begin
        iq_stall_q <= iq_stall_q + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_sched.sv
// Directed testbench for dispatch_sched: fill/full stall, wrap, steering,
// flush recovery, overcommit and asynchronous reset in WAIT_ROB.
module tb_dispatch_sched;
  import dispatch_sched_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  rob_occupancy;
  logic [1:0]  commit_cnt;
  logic        flush_valid;
  logic        flush_robidx_flag;
  logic [5:0]  flush_robidx;
  logic [1:0]  rob_state;
  logic [1:0]  sched_state;
  logic        err_overcommit;
  logic [31:0] stall_rob_full_cnt;
  logic [31:0] stall_iq_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  dispatch_sched_if #(.ROB_SIZE_LOG(6)) bus ();

  dispatch_sched #(.ROB_SIZE(64), .ROB_SIZE_LOG(6), .PERF_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .bus                (bus),
    .rob_occupancy      (rob_occupancy),
    .commit_cnt         (commit_cnt),
    .flush_valid        (flush_valid),
    .flush_robidx_flag  (flush_robidx_flag),
    .flush_robidx       (flush_robidx),
    .rob_state          (rob_state),
    .sched_state        (sched_state),
    .err_overcommit     (err_overcommit),
    .stall_rob_full_cnt (stall_rob_full_cnt),
    .stall_iq_cnt       (stall_iq_cnt)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_idle();
    bus.in_valid      = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_is_store   = 1'b0;
    bus.alu_iq_ready  = 1'b1;
    bus.lsu_iq_ready  = 1'b1;
    commit_cnt        = 2'd0;
    flush_valid       = 1'b0;
    flush_robidx_flag = 1'b0;
    flush_robidx      = 6'd0;
    rob_state         = 2'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (rob_occupancy !== 7'd0) begin n_miss++; $display("[TB] FAIL reset_occ: got %0d want 0", rob_occupancy); end
    n_vec++; if (bus.enq_robidx !== 6'd0) begin n_miss++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.enq_robidx); end
    n_vec++; if (bus.enq_robidx_flag !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_flag: got %0b want 0", bus.enq_robidx_flag); end
    n_vec++; if (sched_state !== 2'd0) begin n_miss++; $display("[TB] FAIL reset_state: got %0d want 0", sched_state); end
    n_vec++; if (err_overcommit !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_err: got %0b want 0", err_overcommit); end
    n_vec++; if (stall_rob_full_cnt !== 32'd0) begin n_miss++; $display("[TB] FAIL reset_full_cnt: got %0d want 0", stall_rob_full_cnt); end
    n_vec++; if (stall_iq_cnt !== 32'd0) begin n_miss++; $display("[TB] FAIL reset_iq_cnt: got %0d want 0", stall_iq_cnt); end
  endtask

  task automatic test_fill();
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      n_vec++; if (bus.enq_robidx !== 6'(i) || bus.enq_robidx_flag !== 1'b0) begin n_miss++; $display("[TB] FAIL fill_idx[%0d]: got %0b/%0d want 0/%0d", i, bus.enq_robidx_flag, bus.enq_robidx, i); end
      n_vec++; if (bus.in_ready !== 1'b1 || bus.alu_iq_valid !== 1'b1) begin n_miss++; $display("[TB] FAIL fill_ready[%0d]: got rdy=%0b alu=%0b want 1/1", i, bus.in_ready, bus.alu_iq_valid); end
      tick();
    end
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL full_ready: got %0b want 0", bus.in_ready); end
    n_vec++; if (bus.alu_iq_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL full_alu_valid: got %0b want 0", bus.alu_iq_valid); end
    n_vec++; if (rob_occupancy !== 7'd64) begin n_miss++; $display("[TB] FAIL full_occ: got %0d want 64", rob_occupancy); end
    n_vec++; if (bus.enq_robidx !== 6'd0 || bus.enq_robidx_flag !== 1'b1) begin n_miss++; $display("[TB] FAIL full_ptr: got %0b/%0d want 1/0", bus.enq_robidx_flag, bus.enq_robidx); end
    n_vec++; if (stall_rob_full_cnt !== 32'd0) begin n_miss++; $display("[TB] FAIL full_cnt0: got %0d want 0", stall_rob_full_cnt); end
    repeat (3) tick();
    #1;
    n_vec++; if (stall_rob_full_cnt !== 32'd3) begin n_miss++; $display("[TB] FAIL full_cnt3: got %0d want 3", stall_rob_full_cnt); end
    n_vec++; if (rob_occupancy !== 7'd64) begin n_miss++; $display("[TB] FAIL full_occ_hold: got %0d want 64", rob_occupancy); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.in_valid = 1'b1;
    repeat (63) tick();
    #1;
    n_vec++; if (rob_occupancy !== 7'd63) begin n_miss++; $display("[TB] FAIL wrap_occ63: got %0d want 63", rob_occupancy); end
    n_vec++; if (bus.enq_robidx !== 6'd63 || bus.enq_robidx_flag !== 1'b0) begin n_miss++; $display("[TB] FAIL wrap_ptr_pre: got %0b/%0d want 0/63", bus.enq_robidx_flag, bus.enq_robidx); end
    commit_cnt = 2'd2;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL wrap_ready: got %0b want 1", bus.in_ready); end
    tick();
    commit_cnt   = 2'd0;
    bus.in_valid = 1'b0;
    #1;
    n_vec++; if (bus.enq_robidx !== 6'd0 || bus.enq_robidx_flag !== 1'b1) begin n_miss++; $display("[TB] FAIL wrap_ptr: got %0b/%0d want 1/0", bus.enq_robidx_flag, bus.enq_robidx); end
    n_vec++; if (rob_occupancy !== 7'd62) begin n_miss++; $display("[TB] FAIL wrap_occ62: got %0d want 62", rob_occupancy); end
  endtask

  // Continues from the wrap scenario: enq_ptr = {1,0}, occupancy 62.
  task automatic test_steering();
    bus.in_valid     = 1'b1;
    bus.in_is_load   = 1'b1;
    bus.lsu_iq_ready = 1'b0;
    bus.alu_iq_ready = 1'b1;
    #1;
    n_vec++; if (bus.lsu_iq_valid !== 1'b1 || bus.alu_iq_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL steer_valids: got lsu=%0b alu=%0b want 1/0", bus.lsu_iq_valid, bus.alu_iq_valid); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL steer_blocked: got %0b want 0", bus.in_ready); end
    tick();
    #1;
    n_vec++; if (stall_iq_cnt !== 32'd1) begin n_miss++; $display("[TB] FAIL steer_iq_cnt: got %0d want 1", stall_iq_cnt); end
    n_vec++; if (bus.enq_robidx !== 6'd0 || bus.enq_robidx_flag !== 1'b1) begin n_miss++; $display("[TB] FAIL steer_hold: got %0b/%0d want 1/0", bus.enq_robidx_flag, bus.enq_robidx); end
    bus.lsu_iq_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL steer_release: got %0b want 1", bus.in_ready); end
    tick();
    bus.in_is_load   = 1'b0;
    bus.in_is_store  = 1'b1;
    bus.alu_iq_ready = 1'b0;
    #1;
    n_vec++; if (bus.enq_robidx !== 6'd1 || stall_iq_cnt !== 32'd1 || rob_occupancy !== 7'd63) begin n_miss++; $display("[TB] FAIL steer_load_fired: got idx=%0d cnt=%0d occ=%0d want 1/1/63", bus.enq_robidx, stall_iq_cnt, rob_occupancy); end
    n_vec++; if (bus.lsu_iq_valid !== 1'b1 || bus.alu_iq_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL steer_store: got lsu=%0b alu=%0b rdy=%0b want 1/0/1", bus.lsu_iq_valid, bus.alu_iq_valid, bus.in_ready); end
    tick();
    drive_idle();
    #1;
    n_vec++; if (bus.enq_robidx !== 6'd2 || rob_occupancy !== 7'd64) begin n_miss++; $display("[TB] FAIL steer_store_fired: got idx=%0d occ=%0d want 2/64", bus.enq_robidx, rob_occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.in_valid = 1'b1;
    repeat (20) tick();
    flush_valid       = 1'b1;
    flush_robidx_flag = 1'b0;
    flush_robidx      = 6'd10;
    rob_state         = 2'd1;
    #1;
    n_vec++; if (bus.enq_robidx !== 6'd20) begin n_miss++; $display("[TB] FAIL flush_pre_idx: got %0d want 20", bus.enq_robidx); end
    n_vec++; if (bus.in_ready !== 1'b0 || bus.alu_iq_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_cycle_ready: got rdy=%0b alu=%0b want 0/0", bus.in_ready, bus.alu_iq_valid); end
    tick();
    flush_valid = 1'b0;
    #1;
    n_vec++; if (sched_state !== 2'd1 || bus.enq_robidx !== 6'd11 || bus.enq_robidx_flag !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_recover: got st=%0d ptr=%0b/%0d want 1 0/11", sched_state, bus.enq_robidx_flag, bus.enq_robidx); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_recover_ready: got %0b want 0", bus.in_ready); end
    tick();
    #1;
    n_vec++; if (sched_state !== 2'd2 || bus.in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_wait1: got st=%0d rdy=%0b want 2/0", sched_state, bus.in_ready); end
    tick();
    rob_state = 2'd0;
    #1;
    n_vec++; if (sched_state !== 2'd2 || bus.in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_wait2: got st=%0d rdy=%0b want 2/0", sched_state, bus.in_ready); end
    tick();
    #1;
    n_vec++; if (sched_state !== 2'd0 || bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL flush_run: got st=%0d rdy=%0b want 0/1", sched_state, bus.in_ready); end
    n_vec++; if (rob_occupancy !== 7'd11) begin n_miss++; $display("[TB] FAIL flush_occ: got %0d want 11", rob_occupancy); end
    bus.in_valid = 1'b0;
  endtask

  // Continues from test_flush: RUN, enq_ptr = {0,11}, deq_ptr = {0,0}.
  task automatic test_flush_wrap();
    bus.in_valid      = 1'b1;
    flush_valid       = 1'b1;
    flush_robidx_flag = 1'b0;
    flush_robidx      = 6'd63;
    rob_state         = 2'd1;
    tick();
    flush_valid = 1'b0;
    #1;
    n_vec++; if (sched_state !== 2'd1 || bus.enq_robidx !== 6'd0 || bus.enq_robidx_flag !== 1'b1) begin n_miss++; $display("[TB] FAIL fwrap_ptr: got st=%0d ptr=%0b/%0d want 1 1/0", sched_state, bus.enq_robidx_flag, bus.enq_robidx); end
    n_vec++; if (rob_occupancy !== 7'd64) begin n_miss++; $display("[TB] FAIL fwrap_occ: got %0d want 64", rob_occupancy); end
    tick();
    #1;
    n_vec++; if (sched_state !== 2'd2 || stall_rob_full_cnt !== 32'd0) begin n_miss++; $display("[TB] FAIL fwrap_wait: got st=%0d fullcnt=%0d want 2/0", sched_state, stall_rob_full_cnt); end
    bus.in_valid = 1'b0;
    flush_valid  = 1'b1;
    flush_robidx = 6'd5;
    tick();
    flush_valid = 1'b0;
    rob_state   = 2'd0;
    #1;
    n_vec++; if (sched_state !== 2'd1 || bus.enq_robidx !== 6'd6 || bus.enq_robidx_flag !== 1'b0) begin n_miss++; $display("[TB] FAIL fwrap_reflush: got st=%0d ptr=%0b/%0d want 1 0/6", sched_state, bus.enq_robidx_flag, bus.enq_robidx); end
    tick();
    #1;
    n_vec++; if (sched_state !== 2'd2) begin n_miss++; $display("[TB] FAIL fwrap_wait2: got %0d want 2", sched_state); end
    tick();
    #1;
    n_vec++; if (sched_state !== 2'd0 || rob_occupancy !== 7'd6) begin n_miss++; $display("[TB] FAIL fwrap_run: got st=%0d occ=%0d want 0/6", sched_state, rob_occupancy); end
  endtask

  task automatic test_overcommit();
    do_reset();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    commit_cnt   = 2'd2;
    #1;
    n_vec++; if (rob_occupancy !== 7'd1) begin n_miss++; $display("[TB] FAIL ovc_pre_occ: got %0d want 1", rob_occupancy); end
    tick();
    commit_cnt = 2'd0;
    #1;
    n_vec++; if (err_overcommit !== 1'b1 || rob_occupancy !== 7'd0) begin n_miss++; $display("[TB] FAIL ovc_err: got err=%0b occ=%0d want 1/0", err_overcommit, rob_occupancy); end
    flush_valid  = 1'b1;
    flush_robidx = 6'd0;
    rob_state    = 2'd1;
    tick();
    flush_valid = 1'b0;
    tick();
    #1;
    n_vec++; if (sched_state !== 2'd2 || err_overcommit !== 1'b1 || bus.enq_robidx !== 6'd1) begin n_miss++; $display("[TB] FAIL ovc_wait: got st=%0d err=%0b idx=%0d want 2/1/1", sched_state, err_overcommit, bus.enq_robidx); end
    #1;
    reset = 1'b1;
    #1;
    n_vec++; if (sched_state !== 2'd0 || err_overcommit !== 1'b0) begin n_miss++; $display("[TB] FAIL async_rst_state: got st=%0d err=%0b want 0/0", sched_state, err_overcommit); end
    n_vec++; if (rob_occupancy !== 7'd0 || bus.enq_robidx !== 6'd0 || bus.enq_robidx_flag !== 1'b0) begin n_miss++; $display("[TB] FAIL async_rst_ptr: got occ=%0d ptr=%0b/%0d want 0 0/0", rob_occupancy, bus.enq_robidx_flag, bus.enq_robidx); end
    n_vec++; if (stall_rob_full_cnt !== 32'd0 || stall_iq_cnt !== 32'd0) begin n_miss++; $display("[TB] FAIL async_rst_cnt: got %0d/%0d want 0/0", stall_rob_full_cnt, stall_iq_cnt); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_fill();
    test_wrap();
    test_steering();
    test_flush();
    test_flush_wrap();
    test_overcommit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dispatch_sched.md
Name: dispatch_sched

Overview:
- Single-lane dispatch controller between rename and the issue queues.
- Owns ROB index allocation: enqueue/dequeue pointers with wrap flags, and an occupancy-based credit check.
- Steers each renamed instruction to the ALU IQ or the LSU IQ and generates the rename-side ready.
- Sequences redirect-flush recovery through a 3-state FSM, and keeps stall performance counters.

Parameters:
- ROB_SIZE, 64, number of ROB entries; must be a power of two.
- ROB_SIZE_LOG, 6, log2(ROB_SIZE); width of a ROB index.
- PERF_W, 32, width of each stall performance counter.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  rename has an instruction.
- in_ready  out  1  dispatch accepts the instruction this cycle.
- in_is_load  in  1  instruction is a load.
- in_is_store  in  1  instruction is a store.
- alu_iq_valid  out  1  instruction presented to the ALU IQ.
- alu_iq_ready  in  1  ALU IQ can accept.
- lsu_iq_valid  out  1  instruction presented to the LSU IQ.
- lsu_iq_ready  in  1  LSU IQ can accept.
- enq_robidx_flag  out  1  wrap flag of the allocated ROB index.
- enq_robidx  out  ROB_SIZE_LOG  allocated ROB index.
- rob_occupancy  out  ROB_SIZE_LOG+1  live ROB entries, range 0..ROB_SIZE.
- commit_cnt  in  2  entries retired this cycle; legal values 0..2.
- flush_valid  in  1  redirect flush.
- flush_robidx_flag  in  1  wrap flag of the flushing instruction.
- flush_robidx  in  ROB_SIZE_LOG  ROB index of the flushing instruction (it survives).
- rob_state  in  2  ROB state; `ROB_STATE_IDLE means walk complete.
- sched_state  out  2  FSM state: RUN=0, RECOVER=1, WAIT_ROB=2.
- err_overcommit  out  1  sticky: a commit exceeded occupancy.
- stall_rob_full_cnt  out  PERF_W  cycles lost to a full ROB.
- stall_iq_cnt  out  PERF_W  cycles lost to a busy target IQ.

Behaviour:
- Pointer and occupancy definitions:
  - Pointers are {flag, idx} of width ROB_SIZE_LOG+1.
  - rob_occupancy = enq_ptr - deq_ptr, computed modulo 2^(ROB_SIZE_LOG+1).
  - full = (rob_occupancy == ROB_SIZE).
  - enq_robidx_flag and enq_robidx are driven directly from enq_ptr.
- Target selection: is_lsu = in_is_load | in_is_store; the target IQ is LSU if is_lsu, otherwise ALU.
- Valid/ready equations:
  - go = in_valid & (state==RUN) & ~flush_valid & ~full & (rob_state==`ROB_STATE_IDLE).
  - alu_iq_valid = go & ~is_lsu.
  - lsu_iq_valid = go & is_lsu.
  - Neither IQ valid depends on that IQ's ready.
  - in_ready = (state==RUN) & ~flush_valid & ~full & (rob_state==`ROB_STATE_IDLE) & target IQ ready.
  - fire = in_valid & in_ready.
- ROB allocation:
  - On fire, enq_ptr increments by 1 at the next edge. The idx wraps ROB_SIZE-1 -> 0 and the flag toggles on wrap.
  - An instruction keeps the same enq_robidx until it fires, so there is no allocation without a handshake.
- Commit:
  - deq_ptr advances by commit_cnt every cycle, in every state.
  - If commit_cnt exceeds rob_occupancy (after this cycle's fire is counted), deq_ptr is set equal to enq_ptr and err_overcommit is set. err_overcommit clears only on reset.
- FSM:
  - flush_valid in any state -> RECOVER; flush has highest priority.
  - RECOVER -> WAIT_ROB unconditionally after one cycle.
  - WAIT_ROB -> RUN when rob_state==`ROB_STATE_IDLE and no flush; otherwise stay.
  - in_ready is 0 in RECOVER and WAIT_ROB.
- Flush restore:
  - In the flush cycle, enq_ptr <= {flush_robidx_flag, flush_robidx} + 1, with wrap and flag toggle.
  - deq_ptr still applies that cycle's commit_cnt.
  - fire is impossible in the flush cycle.
  - A second flush during RECOVER or WAIT_ROB re-restores enq_ptr and returns the FSM to RECOVER.
- Performance counters:
  - stall_rob_full_cnt increments when in_valid & state==RUN & ~flush_valid & full.
  - stall_iq_cnt increments when in_valid & go & ~(target IQ ready).
  - Both counters saturate at all-ones.
- Reset (asynchronous, any cycle, including mid-recovery):
  - enq_ptr = deq_ptr = 0, state = RUN, err_overcommit = 0, both performance counters = 0.
  - Resulting outputs: rob_occupancy = 0, enq_robidx = 0, enq_robidx_flag = 0, sched_state = 0.
  - The combinational outputs follow from these registers.
- Latency: dispatch is zero-cycle combinational pass-through; pointer and occupancy updates are visible the cycle after the event.

Decomposition:
- Shared package entries:
  - Pointer typedef rob_ptr_t {flag, idx}.
  - sched_state_e enum (RUN, RECOVER, WAIT_ROB).
  - ROB_SIZE, ROB_SIZE_LOG and `ROB_STATE_IDLE constants.
- One sub-module, rob_ptr_unit: holds enq_ptr and deq_ptr, performs the wrap-aware add and flush restore, and outputs occupancy and full.
- The FSM, steering and performance counters stay in dispatch_sched.

Test Plan:
- Reset, then 64 back-to-back ALU fires with alu_iq_ready=1 and commit_cnt=0:
  - enq_robidx steps 0..63.
  - After the 64th fire, in_ready=0, rob_occupancy=64, stall_rob_full_cnt increments per stalled cycle.
- Wrap: occupancy 63 with enq_ptr at {0,63}; fire plus commit_cnt=2:
  - enq_ptr becomes {1,0}; rob_occupancy becomes 62.
- Steering: load with lsu_iq_ready=0 and alu_iq_ready=1:
  - lsu_iq_valid=1, alu_iq_valid=0, in_ready=0, stall_iq_cnt increments, enq_robidx held.
  - Raise lsu_iq_ready: instruction fires, enq_robidx increments by 1.
- Flush: flush at {0,10} while enq_ptr={0,20}, rob_state held non-idle for 3 cycles:
  - sched_state goes 1 then 2; enq_ptr becomes {0,11}; in_ready=0 throughout.
  - Returns to RUN the cycle after rob_state==`ROB_STATE_IDLE.
- Flush at {0,63}: enq_ptr becomes {1,0}. A second flush during WAIT_ROB returns sched_state to 1 and re-restores enq_ptr.
- commit_cnt=2 with occupancy 1: err_overcommit=1 and rob_occupancy=0. Then assert reset mid-WAIT_ROB: all registers return to reset values immediately.
